// File: rtl/mem_request_sequencer_if.sv
// CPU-side request ports and SPI memory controller handshake, bundled for the
// request sequencer. The master view belongs to the sequencer; the slave view
// is the surrounding CPU plus controller.
interface mem_request_sequencer_if;
    logic        ifetch_req_in;
    logic [15:0] ifetch_addr_in;
    logic [15:0] ifetch_data_out;
    logic        ifetch_ack_out;

    logic        dmem_req_in;
    logic        dmem_we_in;
    logic [15:0] dmem_addr_in;
    logic [7:0]  dmem_wdata_in;
    logic [7:0]  dmem_rdata_out;
    logic        dmem_ack_out;

    logic [15:0] mem_addr_out;
    logic        mem_addr_valid_out;
    logic [1:0]  mem_type_out;
    logic [7:0]  mem_wdata_out;
    logic [15:0] mem_flash_data_in;
    logic        mem_flash_valid_in;
    logic [7:0]  mem_psram_data_in;
    logic        mem_psram_valid_in;
    logic        mem_busy_in;

    modport master (
        input  ifetch_req_in, ifetch_addr_in,
               dmem_req_in, dmem_we_in, dmem_addr_in, dmem_wdata_in,
               mem_flash_data_in, mem_flash_valid_in,
               mem_psram_data_in, mem_psram_valid_in, mem_busy_in,
        output ifetch_data_out, ifetch_ack_out,
               dmem_rdata_out, dmem_ack_out,
               mem_addr_out, mem_addr_valid_out, mem_type_out, mem_wdata_out
    );

    modport slave (
        output ifetch_req_in, ifetch_addr_in,
               dmem_req_in, dmem_we_in, dmem_addr_in, dmem_wdata_in,
               mem_flash_data_in, mem_flash_valid_in,
               mem_psram_data_in, mem_psram_valid_in, mem_busy_in,
        input  ifetch_data_out, ifetch_ack_out,
               dmem_rdata_out, dmem_ack_out,
               mem_addr_out, mem_addr_valid_out, mem_type_out, mem_wdata_out
    );
endinterface

// File: rtl/mem_request_sequencer.sv
// Memory request sequencer: arbitrates instruction fetch and data requests
// into single SPI controller transactions and keeps a one-word instruction
// prefetch buffer holding the word after the last missed fetch.
module mem_request_sequencer #(
    parameter bit PREFETCH_EN = 1'b1
) (
    input  logic                          clk_in,
    input  logic                          reset_n_in,
    mem_request_sequencer_if.master       bus
);

    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE, ACK} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IFETCH, OWN_DMEM, OWN_PREFETCH} owner_t;

    localparam logic [1:0] TYPE_IDLE   = 2'd0;
    localparam logic [1:0] FLASH_READ  = 2'd1;
    localparam logic [1:0] PSRAM_READ  = 2'd2;
    localparam logic [1:0] PSRAM_WRITE = 2'd3;

    state_t      state;
    owner_t      owner;
    logic        write_op;

    logic        buf_valid;
    logic [15:0] buf_addr;
    logic [15:0] buf_data;
    logic        pf_pending;
    logic [15:0] pf_addr;

    logic [15:0] ifetch_data;
    logic        ifetch_ack;
    logic [7:0]  dmem_rdata;
    logic        dmem_ack;
    logic [15:0] mem_addr;
    logic        mem_addr_valid;
    logic [1:0]  mem_type;
    logic [7:0]  mem_wdata;

    logic [15:0] fetch_word_addr;
    logic        buf_hit;

    // Fetch addresses are word aligned; the hit test compares word addresses.
    assign fetch_word_addr = bus.ifetch_addr_in & 16'hFFFE;
    assign buf_hit         = bus.ifetch_req_in && buf_valid && (fetch_word_addr == buf_addr);

    assign bus.ifetch_data_out    = ifetch_data;
    assign bus.ifetch_ack_out     = ifetch_ack;
    assign bus.dmem_rdata_out     = dmem_rdata;
    assign bus.dmem_ack_out       = dmem_ack;
    assign bus.mem_addr_out       = mem_addr;
    assign bus.mem_addr_valid_out = mem_addr_valid;
    assign bus.mem_type_out       = mem_type;
    assign bus.mem_wdata_out      = mem_wdata;

    // Sequencer FSM: selection, controller handshake, capture and ack pulses.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state          <= IDLE;
            owner          <= OWN_NONE;
            write_op       <= 1'b0;
            buf_valid      <= 1'b0;
            buf_addr       <= '0;
            buf_data       <= '0;
            pf_pending     <= 1'b0;
            pf_addr        <= '0;
            ifetch_data    <= '0;
            ifetch_ack     <= 1'b0;
            dmem_rdata     <= '0;
            dmem_ack       <= 1'b0;
            mem_addr       <= '0;
            mem_addr_valid <= 1'b0;
            mem_type       <= TYPE_IDLE;
            mem_wdata      <= '0;
        end else begin
            // Pulses last one cycle; the type field follows the valid pulse.
            mem_addr_valid <= 1'b0;
            mem_type       <= TYPE_IDLE;
            ifetch_ack     <= 1'b0;
            dmem_ack       <= 1'b0;

            case (state)
                IDLE: begin
                    if (!bus.mem_busy_in) begin
                        if (buf_hit) begin
                            ifetch_data <= buf_data;
                            buf_valid   <= 1'b0;
                            ifetch_ack  <= 1'b1;
                            owner       <= OWN_IFETCH;
                            state       <= ACK;
                        end else if (bus.dmem_req_in) begin
                            mem_addr       <= bus.dmem_addr_in;
                            mem_type       <= bus.dmem_we_in ? PSRAM_WRITE : PSRAM_READ;
                            mem_wdata      <= bus.dmem_wdata_in;
                            mem_addr_valid <= 1'b1;
                            write_op       <= bus.dmem_we_in;
                            owner          <= OWN_DMEM;
                            state          <= WAIT_BUSY;
                        end else if (bus.ifetch_req_in) begin
                            // A miss makes the buffered word and any pending prefetch stale.
                            mem_addr       <= fetch_word_addr;
                            mem_type       <= FLASH_READ;
                            mem_addr_valid <= 1'b1;
                            buf_valid      <= 1'b0;
                            pf_pending     <= 1'b0;
                            write_op       <= 1'b0;
                            owner          <= OWN_IFETCH;
                            state          <= WAIT_BUSY;
                        end else if (PREFETCH_EN && pf_pending) begin
                            mem_addr       <= pf_addr;
                            mem_type       <= FLASH_READ;
                            mem_addr_valid <= 1'b1;
                            write_op       <= 1'b0;
                            owner          <= OWN_PREFETCH;
                            state          <= WAIT_BUSY;
                        end
                    end
                end

                WAIT_BUSY: begin
                    if (bus.mem_busy_in) begin
                        state <= WAIT_DONE;
                    end
                end

                WAIT_DONE: begin
                    // The controller's data valid pulse coincides with busy falling.
                    if (!bus.mem_busy_in) begin
                        case (owner)
                            OWN_IFETCH: begin
                                if (bus.mem_flash_valid_in) begin
                                    ifetch_data <= bus.mem_flash_data_in;
                                end
                                pf_pending <= 1'b1;
                                pf_addr    <= mem_addr + 16'd2;
                                ifetch_ack <= 1'b1;
                                state      <= ACK;
                            end
                            OWN_PREFETCH: begin
                                if (bus.mem_flash_valid_in) begin
                                    buf_data <= bus.mem_flash_data_in;
                                end
                                buf_addr   <= pf_addr;
                                buf_valid  <= 1'b1;
                                pf_pending <= 1'b0;
                                owner      <= OWN_NONE;
                                state      <= IDLE;
                            end
                            OWN_DMEM: begin
                                if (!write_op && bus.mem_psram_valid_in) begin
                                    dmem_rdata <= bus.mem_psram_data_in;
                                end
                                dmem_ack <= 1'b1;
                                state    <= ACK;
                            end
                            default: begin
                                owner <= OWN_NONE;
                                state <= IDLE;
                            end
                        endcase
                    end
                end

                ACK: begin
                    owner <= OWN_NONE;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_request_sequencer.sv
// Randomized self-checking bench for mem_request_sequencer: a behavioural SPI
// controller with its own flash/PSRAM contents, a CPU driver, and a reference
// model of the prefetch buffer kept as a single "which word is buffered" fact.
module tb_mem_request_sequencer;

    localparam logic [1:0] T_IDLE  = 2'd0;
    localparam logic [1:0] T_FLASH = 2'd1;
    localparam logic [1:0] T_PRD   = 2'd2;
    localparam logic [1:0] T_PWR   = 2'd3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_request_sequencer_if bus();

    mem_request_sequencer dut (
        .clk_in     (clk),
        .reset_n_in (rst_n),
        .bus        (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Memory contents seen by the controller model, plus the reference PSRAM image.
    logic [15:0] flash     [0:32767];
    logic [7:0]  psram     [0:65535];
    logic [7:0]  ref_psram [0:65535];

    // Reference model of the prefetch buffer.
    bit          m_buf_valid = 1'b0;
    logic [15:0] m_buf_addr  = '0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [15:0] addr;
        logic [1:0]  typ;
        logic [7:0]  wdata;
    } txn_t;
    txn_t txq[$];
    int   fall_cyc = 0;

    // Controller model: busy one cycle after the valid pulse, random length,
    // data valid pulse together with busy falling.
    initial begin : ctrl_model
        txn_t t;
        int   n;
        bus.mem_busy_in        = 1'b0;
        bus.mem_flash_valid_in = 1'b0;
        bus.mem_psram_valid_in = 1'b0;
        bus.mem_flash_data_in  = '0;
        bus.mem_psram_data_in  = '0;
        forever begin
            @(negedge clk);
            bus.mem_flash_valid_in = 1'b0;
            bus.mem_psram_valid_in = 1'b0;
            if (rst_n && bus.mem_addr_valid_out === 1'b1) begin
                t.addr  = bus.mem_addr_out;
                t.typ   = bus.mem_type_out;
                t.wdata = bus.mem_wdata_out;
                txq.push_back(t);
                bus.mem_busy_in = 1'b1;
                n = $urandom_range(1, 4);
                for (int i = 0; i < n; i++) begin
                    @(negedge clk);
                    if (!rst_n) break;
                end
                bus.mem_busy_in = 1'b0;
                if (rst_n) begin
                    fall_cyc = cyc;
                    case (t.typ)
                        T_FLASH: begin
                            bus.mem_flash_data_in  = flash[t.addr[15:1]];
                            bus.mem_flash_valid_in = 1'b1;
                        end
                        T_PRD: begin
                            bus.mem_psram_data_in  = psram[t.addr];
                            bus.mem_psram_valid_in = 1'b1;
                        end
                        T_PWR: psram[t.addr] = t.wdata;
                        default: ;
                    endcase
                end
            end
        end
    end

    int n_iack = 0;
    int n_dack = 0;
    initial begin : ack_monitor
        forever begin
            @(negedge clk);
            if (bus.ifetch_ack_out === 1'b1) n_iack++;
            if (bus.dmem_ack_out === 1'b1) n_dack++;
        end
    end

    // After a missed fetch of word aa the model expects exactly one prefetch of aa+2.
    task automatic expect_prefetch(input int base, input logic [15:0] aa);
        logic [15:0] nxt;
        nxt = aa + 16'd2;
        repeat (12) @(negedge clk);
        check_val("prefetch_count", txq.size() - base, 1);
        if (txq.size() > base) begin
            check_val("prefetch_addr", txq[base].addr, nxt);
            check_val("prefetch_type", txq[base].typ, T_FLASH);
        end
        m_buf_valid = 1'b1;
        m_buf_addr  = nxt;
    endtask

    task automatic do_ifetch(input logic [15:0] a);
        logic [15:0] aa;
        bit          hit;
        bit          seen;
        int          base;
        int          waited;
        aa   = a & 16'hFFFE;
        hit  = m_buf_valid && (m_buf_addr == aa);
        base = txq.size();
        bus.ifetch_addr_in = a;
        bus.ifetch_req_in  = 1'b1;
        seen   = 1'b0;
        waited = 0;
        while (!seen && waited < 60) begin
            @(negedge clk);
            waited++;
            if (bus.ifetch_ack_out === 1'b1) seen = 1'b1;
        end
        bus.ifetch_req_in = 1'b0;
        check_val("ifetch_ack", seen, 1);
        if (seen) begin
            check_val("ifetch_data", bus.ifetch_data_out, flash[aa[15:1]]);
            if (hit) begin
                check_val("hit_latency", waited, 1);
                check_val("hit_no_access", txq.size() - base, 0);
                m_buf_valid = 1'b0;
            end else begin
                check_val("miss_access", txq.size() - base, 1);
                if (txq.size() > base) begin
                    check_val("miss_addr", txq[base].addr, aa);
                    check_val("miss_type", txq[base].typ, T_FLASH);
                end
                check_val("miss_ack_lat", cyc, fall_cyc + 1);
            end
            @(negedge clk);
            check_val("ifetch_ack_width", bus.ifetch_ack_out, 0);
            if (!hit) begin
                m_buf_valid = 1'b0;
                expect_prefetch(base + 1, aa);
            end
        end
    endtask

    task automatic do_dmem(input bit we, input logic [15:0] a, input logic [7:0] wd);
        bit seen;
        int base;
        int waited;
        base = txq.size();
        bus.dmem_we_in    = we;
        bus.dmem_addr_in  = a;
        bus.dmem_wdata_in = wd;
        bus.dmem_req_in   = 1'b1;
        seen   = 1'b0;
        waited = 0;
        while (!seen && waited < 60) begin
            @(negedge clk);
            waited++;
            if (bus.dmem_ack_out === 1'b1) seen = 1'b1;
        end
        bus.dmem_req_in = 1'b0;
        check_val("dmem_ack", seen, 1);
        if (seen) begin
            check_val("dmem_access", txq.size() - base, 1);
            if (txq.size() > base) begin
                check_val("dmem_addr", txq[base].addr, a);
                check_val("dmem_type", txq[base].typ, we ? T_PWR : T_PRD);
                if (we) check_val("dmem_wdata", txq[base].wdata, wd);
            end
            check_val("dmem_ack_lat", cyc, fall_cyc + 1);
            if (!we) check_val("dmem_rdata", bus.dmem_rdata_out, ref_psram[a]);
            @(negedge clk);
            check_val("dmem_ack_width", bus.dmem_ack_out, 0);
        end
        if (we) ref_psram[a] = wd;
        repeat (2) @(negedge clk);
    endtask

    // Fetch and data read raised together: data port must win.
    task automatic do_both(input logic [15:0] ia, input logic [15:0] da);
        int  base;
        int  ic;
        int  dc;
        bit  i_seen;
        bit  d_seen;
        logic [15:0] idata;
        logic [7:0]  ddata;
        base = txq.size();
        bus.ifetch_addr_in = ia;
        bus.dmem_addr_in   = da;
        bus.dmem_we_in     = 1'b0;
        bus.ifetch_req_in  = 1'b1;
        bus.dmem_req_in    = 1'b1;
        i_seen = 1'b0;
        d_seen = 1'b0;
        ic = 0;
        dc = 0;
        idata = '0;
        ddata = '0;
        for (int w = 1; w <= 80 && !(i_seen && d_seen); w++) begin
            @(negedge clk);
            if (bus.dmem_ack_out === 1'b1 && !d_seen) begin
                d_seen = 1'b1; dc = w; ddata = bus.dmem_rdata_out; bus.dmem_req_in = 1'b0;
            end
            if (bus.ifetch_ack_out === 1'b1 && !i_seen) begin
                i_seen = 1'b1; ic = w; idata = bus.ifetch_data_out; bus.ifetch_req_in = 1'b0;
            end
        end
        bus.ifetch_req_in = 1'b0;
        bus.dmem_req_in   = 1'b0;
        check_val("both_dmem_ack", d_seen, 1);
        check_val("both_ifetch_ack", i_seen, 1);
        check_val("both_order", (dc < ic), 1);
        check_val("both_rdata", ddata, ref_psram[da]);
        check_val("both_idata", idata, flash[ia[15:1]]);
        check_val("both_access", txq.size() - base, 2);
        if (txq.size() >= base + 2) begin
            check_val("both_first_type", txq[base].typ, T_PRD);
            check_val("both_first_addr", txq[base].addr, da);
            check_val("both_second_type", txq[base + 1].typ, T_FLASH);
            check_val("both_second_addr", txq[base + 1].addr, ia & 16'hFFFE);
        end
        m_buf_valid = 1'b0;
        expect_prefetch(base + 2, ia & 16'hFFFE);
    endtask

    initial begin : main
        int          kind;
        int          base;
        int          base_i;
        int          base_d;
        int          waited;
        bit          busy_seen;
        logic [15:0] a;

        for (int i = 0; i < 32768; i++) flash[i] = 16'($urandom);
        for (int i = 0; i < 65536; i++) begin
            psram[i]     = 8'($urandom);
            ref_psram[i] = psram[i];
        end
        flash[16'h0010 >> 1] = 16'hA55A;
        flash[16'h0012 >> 1] = 16'h1234;
        psram[16'h0100]      = 8'h7E;
        ref_psram[16'h0100]  = 8'h7E;

        bus.ifetch_req_in  = 1'b0;
        bus.ifetch_addr_in = '0;
        bus.dmem_req_in    = 1'b0;
        bus.dmem_we_in     = 1'b0;
        bus.dmem_addr_in   = '0;
        bus.dmem_wdata_in  = '0;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_ifetch_ack", bus.ifetch_ack_out, 0);
        check_val("rst_dmem_ack", bus.dmem_ack_out, 0);
        check_val("rst_valid", bus.mem_addr_valid_out, 0);
        check_val("rst_type", bus.mem_type_out, T_IDLE);
        check_val("rst_addr", bus.mem_addr_out, 0);
        check_val("rst_idata", bus.ifetch_data_out, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed scenarios.
        do_ifetch(16'h0010);
        do_ifetch(16'h0013);
        do_both(16'h0400, 16'h0100);
        do_dmem(1'b1, 16'h0200, 8'hC3);
        do_dmem(1'b0, 16'h0200, 8'h00);
        do_ifetch(16'hFFFE);
        do_ifetch(16'h0001);

        // Reset while the controller is busy with a fetch.
        base_i = n_iack;
        base_d = n_dack;
        bus.ifetch_addr_in = 16'h2468;
        bus.ifetch_req_in  = 1'b1;
        busy_seen = 1'b0;
        waited    = 0;
        while (!busy_seen && waited < 20) begin
            @(negedge clk);
            waited++;
            if (bus.mem_busy_in === 1'b1) busy_seen = 1'b1;
        end
        check_val("rst_busy_seen", busy_seen, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_ifetch_ack", bus.ifetch_ack_out, 0);
        check_val("arst_idata", bus.ifetch_data_out, 0);
        check_val("arst_dmem", {bus.dmem_ack_out, bus.dmem_rdata_out}, 0);
        check_val("arst_mem", {bus.mem_addr_out, bus.mem_addr_valid_out, bus.mem_type_out, bus.mem_wdata_out}, 0);
        bus.ifetch_req_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_buf_valid = 1'b0;
        base = txq.size();
        repeat (10) @(negedge clk);
        check_val("no_ack_after_rst", n_iack - base_i + n_dack - base_d, 0);
        check_val("no_access_after_rst", txq.size() - base, 0);
        do_ifetch(16'h2468);

        // Randomized mix of fetches (with deliberate buffer hits) and data accesses.
        for (int k = 0; k < 40; k++) begin
            kind = $urandom_range(0, 3);
            if (kind < 2) begin
                if (m_buf_valid && $urandom_range(0, 1) == 1)
                    a = m_buf_addr | 16'($urandom_range(0, 1));
                else
                    a = 16'($urandom);
                do_ifetch(a);
            end else begin
                do_dmem(kind == 3, 16'h0100 | 16'($urandom_range(0, 15)), 8'($urandom));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
